// File: rtl/psu_sw_seq.sv
// PSU soft-switch sequencer: drives PS_ON, waits for PWROK, then
// issues a stable power-good; enforces minimum off time and flags faults.
module psu_sw_seq #(
  parameter int MULTIPLIER       = 2,
  parameter int PWROK_TIMEOUT_US = 1000,
  parameter int ON_DLY_US        = 100,
  parameter int OFF_DLY_US       = 100
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iEnable,
  input  logic       iPsuPwrok,
  output logic       oPsuOn_n,
  output logic       oPwrgd,
  output logic       oFault,
  output logic [2:0] oState
);

  localparam int TO_T  = PWROK_TIMEOUT_US * MULTIPLIER;
  localparam int ON_T  = ON_DLY_US * MULTIPLIER;
  localparam int OFF_T = OFF_DLY_US * MULTIPLIER;

  generate
    if (TO_T < 1 || TO_T > 65535) begin : g_bad_to
      $error("psu_sw_seq: PWROK timeout out of 16-bit range");
    end
    if (ON_T < 1 || ON_T > 65535) begin : g_bad_on
      $error("psu_sw_seq: ON delay out of 16-bit range");
    end
    if (OFF_T < 1 || OFF_T > 65535) begin : g_bad_off
      $error("psu_sw_seq: OFF delay out of 16-bit range");
    end
  endgenerate

  localparam logic [15:0] TO_M1  = 16'(TO_T - 1);
  localparam logic [15:0] ON_M1  = 16'(ON_T - 1);
  localparam logic [15:0] OFF_M1 = 16'(OFF_T - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ON_WAIT = 3'd1,
    ON_DLY  = 3'd2,
    ON      = 3'd3,
    OFF_DLY = 3'd4,
    FAULT   = 3'd5
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [15:0] timer;
  logic        sync1;
  logic        pwrok;
  logic        timed;
  logic        expired;

  always_comb begin
    timed   = 1'b0;
    expired = 1'b0;
    unique case (1'b1)
      (state == ON_WAIT): begin
        timed   = 1'b1;
        expired = (timer == TO_M1);
      end
      (state == ON_DLY): begin
        timed   = 1'b1;
        expired = (timer == ON_M1);
      end
      (state == OFF_DLY): begin
        timed   = 1'b1;
        expired = (timer == OFF_M1);
      end
      default: ;
    endcase
  end

  // Disable always wins over pwrok loss so a clean shutdown never faults
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (iEnable) nxt = ON_WAIT;
      ON_WAIT: begin
        if (!iEnable)    nxt = OFF_DLY;
        else if (pwrok)  nxt = ON_DLY;
        else if (expired) nxt = FAULT;
      end
      ON_DLY: begin
        if (!iEnable)     nxt = OFF_DLY;
        else if (!pwrok)  nxt = FAULT;
        else if (expired) nxt = ON;
      end
      ON: begin
        if (!iEnable)    nxt = OFF_DLY;
        else if (!pwrok) nxt = FAULT;
      end
      OFF_DLY: if (expired) nxt = IDLE;
      FAULT:   if (!iEnable) nxt = OFF_DLY;
      default: nxt = OFF_DLY;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync1    <= 1'b0;
      pwrok    <= 1'b0;
      state    <= IDLE;
      timer    <= '0;
      oPsuOn_n <= 1'b1;
      oPwrgd   <= 1'b0;
      oFault   <= 1'b0;
      oState   <= 3'd0;
    end else begin
      sync1 <= iPsuPwrok;
      pwrok <= sync1;
      state <= nxt;
      if (nxt != state)
        timer <= '0;
      else if (timed)
        timer <= timer + 16'd1;
      oPsuOn_n <= !(nxt == ON_WAIT || nxt == ON_DLY || nxt == ON);
      oPwrgd   <= (nxt == ON);
      oFault   <= (nxt == FAULT);
      oState   <= nxt;
    end
  end

endmodule

// File: tb/tb_psu_sw_seq.sv
// Directed bench for psu_sw_seq; expected outputs are queued with the
// cycle they are due on and checked when that cycle arrives.
module tb_psu_sw_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       pw = 1'b0;
  logic       on_n;
  logic       pg;
  logic       flt;
  logic [2:0] st;

  int nchk  = 0;
  int nfail = 0;
  int cycle = 0;

  typedef struct {
    int         cyc;
    string      tag;
    logic [2:0] st;
    logic       onn;
    logic       pg;
    logic       flt;
  } exp_t;

  exp_t q[$];

  psu_sw_seq #(
    .MULTIPLIER      (2),
    .PWROK_TIMEOUT_US(10),
    .ON_DLY_US       (4),
    .OFF_DLY_US      (3)
  ) dut (
    .iClk     (clk),
    .iRst_n   (rst_n),
    .iEnable  (en),
    .iPsuPwrok(pw),
    .oPsuOn_n (on_n),
    .oPwrgd   (pg),
    .oFault   (flt),
    .oState   (st)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_at(input int dly, input string tag,
                           input logic [2:0] s, input logic o,
                           input logic g, input logic f);
    exp_t e;
    e.cyc = cycle + dly;
    e.tag = tag;
    e.st  = s;
    e.onn = o;
    e.pg  = g;
    e.flt = f;
    q.push_back(e);
  endtask

  task automatic check_now();
    int i = 0;
    while (i < q.size()) begin
      if (q[i].cyc == cycle) begin
        cmp({q[i].tag, ".state"}, 32'(st), 32'(q[i].st));
        cmp({q[i].tag, ".on_n"}, 32'(on_n), 32'(q[i].onn));
        cmp({q[i].tag, ".pwrgd"}, 32'(pg), 32'(q[i].pg));
        cmp({q[i].tag, ".fault"}, 32'(flt), 32'(q[i].flt));
        q.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    check_now();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bring_on();
    int n = 0;
    en = 1'b1;
    pw = 1'b1;
    while (st !== 3'd3 && n < 60) begin
      tick();
      n++;
    end
    cmp("bring_on", 32'(st), 32'd3);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    expect_at(0, "rst_async", 3'd0, 1'b1, 1'b0, 1'b0);
    check_now();
    ticks(2);
    rst_n = 1'b1;
    expect_at(1, "idle", 3'd0, 1'b1, 1'b0, 1'b0);
    tick();

    // normal power-on
    en = 1'b1;
    expect_at(1, "on_wait", 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    ticks(5);
    pw = 1'b1;
    expect_at(2, "ondly_pre", 3'd1, 1'b0, 1'b0, 1'b0);
    expect_at(3, "ondly", 3'd2, 1'b0, 1'b0, 1'b0);
    expect_at(10, "ondly_last", 3'd2, 1'b0, 1'b0, 1'b0);
    expect_at(11, "on", 3'd3, 1'b0, 1'b1, 1'b0);
    ticks(11);

    // pwrok loss in ON
    pw = 1'b0;
    expect_at(2, "loss_pre", 3'd3, 1'b0, 1'b1, 1'b0);
    expect_at(3, "loss_fault", 3'd5, 1'b1, 1'b0, 1'b1);
    ticks(3);
    expect_at(3, "fault_hold", 3'd5, 1'b1, 1'b0, 1'b1);
    ticks(3);
    en = 1'b0;
    expect_at(1, "flt_off", 3'd4, 1'b1, 1'b0, 1'b0);
    expect_at(6, "off_last", 3'd4, 1'b1, 1'b0, 1'b0);
    expect_at(7, "off_idle", 3'd0, 1'b1, 1'b0, 1'b0);
    ticks(7);

    // pwrok timeout
    en = 1'b1;
    expect_at(1, "to_wait", 3'd1, 1'b0, 1'b0, 1'b0);
    expect_at(20, "to_last", 3'd1, 1'b0, 1'b0, 1'b0);
    expect_at(21, "to_fault", 3'd5, 1'b1, 1'b0, 1'b1);
    ticks(21);
    en = 1'b0;
    expect_at(1, "to_off", 3'd4, 1'b1, 1'b0, 1'b0);
    expect_at(7, "to_idle", 3'd0, 1'b1, 1'b0, 1'b0);
    ticks(7);

    // off with enable pulse during OFF_DLY
    bring_on();
    en = 1'b0;
    expect_at(1, "off", 3'd4, 1'b1, 1'b0, 1'b0);
    tick();
    en = 1'b1;
    expect_at(1, "off_ign", 3'd4, 1'b1, 1'b0, 1'b0);
    tick();
    en = 1'b0;
    expect_at(5, "pulse_idle", 3'd0, 1'b1, 1'b0, 1'b0);
    expect_at(6, "pulse_stay", 3'd0, 1'b1, 1'b0, 1'b0);
    ticks(6);

    // enable held through OFF_DLY re-arms after IDLE
    bring_on();
    en = 1'b0;
    tick();
    en = 1'b1;
    expect_at(5, "reen_off", 3'd4, 1'b1, 1'b0, 1'b0);
    expect_at(6, "reen_idle", 3'd0, 1'b1, 1'b0, 1'b0);
    expect_at(7, "reen_wait", 3'd1, 1'b0, 1'b0, 1'b0);
    ticks(7);

    // simultaneous disable and pwrok loss
    bring_on();
    en = 1'b0;
    pw = 1'b0;
    expect_at(1, "sim_off", 3'd4, 1'b1, 1'b0, 1'b0);
    expect_at(3, "sim_nofault", 3'd4, 1'b1, 1'b0, 1'b0);
    expect_at(7, "sim_idle", 3'd0, 1'b1, 1'b0, 1'b0);
    ticks(7);

    // async reset in ON_DLY
    en = 1'b1;
    expect_at(1, "r_wait", 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    pw = 1'b1;
    expect_at(3, "r_ondly", 3'd2, 1'b0, 1'b0, 1'b0);
    ticks(3);
    #3 rst_n = 1'b0;
    #1;
    expect_at(0, "arst_mid", 3'd0, 1'b1, 1'b0, 1'b0);
    check_now();
    en = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    expect_at(1, "post_idle", 3'd0, 1'b1, 1'b0, 1'b0);
    expect_at(3, "post_idle3", 3'd0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    en = 1'b1;
    expect_at(1, "restart", 3'd1, 1'b0, 1'b0, 1'b0);
    expect_at(2, "restart_dly", 3'd2, 1'b0, 1'b0, 1'b0);
    ticks(2);

    cmp("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
